// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and state encoding for the program loader
package cpu_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam logic [7:0]  BASE_ADDR_DEF = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CHECK = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

endpackage

// File: rtl/loader_csum.sv
// rtl/loader_csum.sv - XOR checksum accumulator with synchronous clear
module loader_csum
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] csum_o
);

    logic [DATA_W-1:0] acc_q, acc_d;

    // Clear wins over accumulate so a restart never folds in a stale byte.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q ^ data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign csum_o = acc_q;

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a length-prefixed, XOR-checked program into instruction memory
module prog_loader
    import cpu_pkg::*;
#(
    parameter int unsigned          DATA_W    = DATA_W_DEF,
    parameter int unsigned          ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = ADDR_W'(BASE_ADDR_DEF)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    // Counts are one bit wider than a byte so a length byte of 0 can mean 2^DATA_W.
    localparam logic [DATA_W:0] FULL_COUNT = {1'b1, {DATA_W{1'b0}}};
    localparam logic [DATA_W:0] ONE        = {{DATA_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [DATA_W:0]   n_q, n_d;
    logic [DATA_W:0]   cnt_q, cnt_d;
    logic [DATA_W:0]   cnt_inc;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] csum;
    logic              xfer;
    logic              load_xfer;

    assign in_ready  = ((state_q == ST_LEN) || (state_q == ST_LOAD) || (state_q == ST_CHECK)) && !start;
    assign xfer      = in_valid && in_ready;
    assign load_xfer = xfer && (state_q == ST_LOAD);
    assign cnt_inc   = cnt_q + ONE;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = ST_LEN;
            cnt_d   = '0;
        end else if (xfer) begin
            case (state_q)
                ST_LEN: begin
                    n_d     = (in_data == '0) ? FULL_COUNT : {1'b0, in_data};
                    state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == n_q) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state_d = (in_data == csum) ? ST_RUN : ST_ERR;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Write port is registered: the strobe appears the cycle after the byte is taken.
    always_comb begin
        mem_we_d    = load_xfer;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (load_xfer) begin
            mem_addr_d  = BASE_ADDR + ADDR_W'(cnt_q);
            mem_wdata_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    loader_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (start),
        .en_i    (load_xfer),
        .data_i  (in_data),
        .csum_o  (csum)
    );

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_reset = (state_q != ST_RUN);
    assign done      = (state_q == ST_RUN);
    assign error     = (state_q == ST_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader memory writes and status
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_reset;
    logic       done;
    logic       error;

    int tests = 0;
    int fails = 0;

    logic [15:0] sb[$];

    prog_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic v, input logic [7:0] d);
        @(negedge clk);
        start    = s;
        in_valid = v;
        in_data  = d;
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        sb.push_back({a, d});
    endtask

    // Monitor: every write strobe must match the next expected write.
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (mem_we === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got %h@%h expected none", mem_wdata, mem_addr);
                end else begin
                    e = sb.pop_front();
                    chk("write_addr_data", {mem_addr, mem_wdata}, e);
                end
            end
        end
    end

    task automatic status(input string name, input logic d, input logic er, input logic cr);
        chk({name, "_done"},  {15'd0, done},      {15'd0, d});
        chk({name, "_error"}, {15'd0, error},     {15'd0, er});
        chk({name, "_cpurst"},{15'd0, cpu_reset}, {15'd0, cr});
    endtask

    task automatic drain(input string name);
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);
        chk({name, "_sb_empty"}, 16'(sb.size()), 16'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #3;
        chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
        chk("rst_mem_we",   {15'd0, mem_we},   16'd0);
        chk("rst_mem_addr", {8'd0, mem_addr},  16'h0000);
        chk("rst_wdata",    {8'd0, mem_wdata}, 16'h0000);
        status("rst", 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Back-to-back good load
        cyc(1, 0, 8'h00);
        expect_wr(8'h00, 8'h11); expect_wr(8'h01, 8'h22); expect_wr(8'h02, 8'h44);
        cyc(0, 1, 8'h03); cyc(0, 1, 8'h11); cyc(0, 1, 8'h22); cyc(0, 1, 8'h44); cyc(0, 1, 8'h77);
        cyc(0, 0, 8'h00);
        status("good", 1'b1, 1'b0, 1'b0);
        chk("run_in_ready", {15'd0, in_ready}, 16'd0);
        drain("good");

        // Bad checksum
        cyc(1, 0, 8'h00);
        expect_wr(8'h00, 8'hA5); expect_wr(8'h01, 8'h5A);
        cyc(0, 1, 8'h02); cyc(0, 1, 8'hA5); cyc(0, 1, 8'h5A); cyc(0, 1, 8'h00);
        cyc(0, 0, 8'h00);
        status("bad", 1'b0, 1'b1, 1'b1);
        drain("bad");

        // Gap cycles mid-load
        cyc(1, 0, 8'h00);
        expect_wr(8'h00, 8'h01); expect_wr(8'h01, 8'h02);
        cyc(0, 1, 8'h02); cyc(0, 1, 8'h01);
        cyc(0, 0, 8'h00); cyc(0, 0, 8'h00); cyc(0, 0, 8'h00);
        cyc(0, 1, 8'h02); cyc(0, 1, 8'h03);
        cyc(0, 0, 8'h00);
        status("gap", 1'b1, 1'b0, 1'b0);
        drain("gap");

        // Restart coincident with second load byte
        cyc(1, 0, 8'h00);
        expect_wr(8'h00, 8'h11);
        cyc(0, 1, 8'h03); cyc(0, 1, 8'h11);
        cyc(1, 1, 8'h22);
        #1;
        chk("restart_in_ready", {15'd0, in_ready}, 16'd0);
        expect_wr(8'h00, 8'h33); expect_wr(8'h01, 8'h44);
        cyc(0, 1, 8'h02);
        chk("restart_cpurst", {15'd0, cpu_reset}, 16'd1);
        cyc(0, 1, 8'h33); cyc(0, 1, 8'h44); cyc(0, 1, 8'h77);
        cyc(0, 0, 8'h00);
        status("restart", 1'b1, 1'b0, 1'b0);
        drain("restart");

        // Asynchronous reset during LOAD
        cyc(1, 0, 8'h00);
        expect_wr(8'h00, 8'hAA); expect_wr(8'h01, 8'hBB);
        cyc(0, 1, 8'h04); cyc(0, 1, 8'hAA); cyc(0, 1, 8'hBB);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_mem_we",   {15'd0, mem_we},   16'd0);
        chk("arst_mem_addr", {8'd0, mem_addr},  16'h0000);
        chk("arst_wdata",    {8'd0, mem_wdata}, 16'h0000);
        chk("arst_in_ready", {15'd0, in_ready}, 16'd0);
        status("arst", 1'b0, 1'b0, 1'b1);
        cyc(0, 1, 8'hCC);
        cyc(0, 1, 8'hDD);
        reset_n = 1'b1;
        cyc(0, 1, 8'hEE);
        chk("post_arst_in_ready", {15'd0, in_ready}, 16'd0);
        drain("arst");

        // Full 256-byte load, XOR of 0..255 is 00
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h00);
        for (int i = 0; i < 256; i++) begin
            expect_wr(8'(i), 8'(i));
            cyc(0, 1, 8'(i));
        end
        chk("full_in_check_cpurst", {15'd0, cpu_reset}, 16'd1);
        cyc(0, 1, 8'h00);
        cyc(0, 0, 8'h00);
        status("full", 1'b1, 1'b0, 1'b0);
        drain("full");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
